fb_addr_gen: RTL and testbench
==============================

# fb_addr_gen

Registered, parametrised frame-buffer address generator between the VGA timing counters and the frame-buffer read port. It maps raster position (hcnt, vcnt, dena) to a linear frame-buffer address using incremental counters, with no multiplier. It places a buffer of configurable size at a configurable offset inside the active area and blanks everything outside it. Optionally it up-scales a half-resolution buffer by 2x2 pixel replication.

## Interface
- H_W, 10, width of hcnt
- V_W, 10, width of vcnt
- ADDR_W, 19, address width; FB_W*FB_H <= 2^ADDR_W (elaboration check)
- H_ACT_START, 144, hcnt value of first active pixel
- V_ACT_START, 35, vcnt value of first active line
- FB_W, 640, buffer width in pixels
- FB_H, 480, buffer height in lines
- H_OFF, 0, window left edge, in screen pixels from active start
- V_OFF, 0, window top edge, in screen lines from active start

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; one clock; synchronous, active-high
- hcnt  in  H_W  horizontal raster counter
- vcnt  in  V_W  vertical raster counter
- dena  in  1  display enable from timing generator
- scale2  in  1  2x2 replication select; exists only with FB_ADDR_SCALE2_EN
- fb_addr  out  ADDR_W  frame-buffer read address
- black_flag  out  1  1 = drive colour zero for this pixel
- addr_valid  out  1  1 = fb_addr points at a real buffer pixel (equals ~black_flag)
- frame_start  out  1  one-cycle pulse coinciding with the address-0 output of each frame

## Operation
- Scale factor S = 2 when scale2=1 (macro on), else 1. Window size is WIN_W = FB_W*S by WIN_H = FB_H*S screen pixels.
- Relative coordinates: hx = hcnt − H_ACT_START, vy = vcnt − V_ACT_START, computed modulo 2^H_W and 2^V_W (negative values wrap to large values and therefore fall outside the window).
- in_win = dena & armed & (H_OFF <= hx < H_OFF+WIN_W) & (V_OFF <= vy < V_OFF+WIN_H).
- State registers:
  - col (ADDR_W)
  - row_base (ADDR_W)
  - sub_h, sub_v (1 bit each)
  - armed (1 bit)
  - prev_in_win (1 bit)
- Frame re-arm: any cycle with vcnt < V_ACT_START sets armed=1 and clears col, row_base, sub_h and sub_v to 0.
- Cycle with in_win=1:
  - fb_addr <= row_base + col; black_flag <= 0.
  - If S=1: col++.
  - If S=2: sub_h toggles, and col++ only when sub_h was 1.
- Cycle with in_win=0 and prev_in_win=1 (end of window line):
  - col <= 0; sub_h <= 0.
  - If S=1: row_base += FB_W.
  - If S=2: sub_v toggles, and row_base += FB_W only when sub_v was 1.
- Cycle with in_win=0: fb_addr <= 0; black_flag <= 1.
- frame_start <= in_win & (row_base==0) & (col==0) & ~prev_in_win & (sub_v==0).
- scale2 is sampled only in cycles where the re-arm condition holds. A change mid-frame takes effect at the next frame.
- Reset (rst=1):
  - fb_addr=0, black_flag=1, addr_valid=0, frame_start=0.
  - All state cleared; armed=0.
  - A reset mid-frame therefore blanks the output until the next vertical blanking, so no wrong addresses are issued.

## Timing
- Latency: exactly 1 clk from (hcnt, vcnt, dena) to (fb_addr, black_flag, addr_valid, frame_start). The frame-buffer read latency is added downstream; the timing generator's sync outputs must be delayed to match.
- Outputs are all registers; there is no combinational input-to-output path.
- The last buffer pixel yields address FB_W*FB_H−1. row_base must never exceed FB_W*(FB_H−1).
- No wrap-around inside a frame. The line counter is bounded by the window test, not by address overflow.

## Configuration
- FB_ADDR_SCALE2_EN defined:
  - scale2 port present.
  - sub_h/sub_v logic built.
  - 2x2 replication is available at runtime.
- Undefined:
  - scale2 port absent.
  - S is fixed at 1.
  - sub_h/sub_v are removed.

## Structure
- Shared package fb_pkg:
  - Default VGA 640x480 timing constants (H_ACT_START=144, V_ACT_START=35, 640, 480).
  - ADDR_W.
  - A function computing WIN_W/WIN_H from S.
- Natural sub-module fb_win_detect: combinational hx/vy subtraction and in_win compare, reusable by the overlay logic.
- The counter/state logic stays in fb_addr_gen.

## Test plan
- Defaults, full frame: (hcnt=144, vcnt=35) → next cycle fb_addr=0, black_flag=0, frame_start=1; (783, 35) → 639; (144, 36) → 640; (783, 514) → 307199.
- Blanking: hcnt=143 or 784, or vcnt=34 or 515, or dena=0 → black_flag=1, fb_addr=0, addr_valid=0.
- Offset window, FB_W=320, FB_H=240, H_OFF=160, V_OFF=120: (303, 155) → black; (304, 155) → fb_addr 0; (623, 155) → 319; (304, 156) → 320.
- Scale2, FB_W=320, FB_H=240: line vcnt=35 at hcnt 144, 145, 146 → 0, 0, 1; line vcnt=36 at hcnt 144 → 0; line vcnt=37 at hcnt 144 → 320; (783, 514) → 76799.
- rst asserted for 1 cycle at (400, 200) → outputs black for the rest of the frame; after vcnt passes through 0, (144, 35) → fb_addr 0, frame_start=1.
- scale2 toggled at vcnt=200 → addresses for the current frame are unchanged; the new mode applies from the next frame.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer address path: default VGA 640x480
// timing, address width and the window-size helper used by fb_win_detect.
package fb_pkg;

    localparam int DEF_H_ACT_START = 144;
    localparam int DEF_V_ACT_START = 35;
    localparam int DEF_FB_W        = 640;
    localparam int DEF_FB_H        = 480;
    localparam int DEF_ADDR_W      = 19;

    // Window extent in screen pixels for one buffer dimension at scale 1 or 2.
    function automatic int win_dim(input int fb_dim, input logic s2);
        return s2 ? fb_dim * 2 : fb_dim;
    endfunction

endpackage

// File: rtl/fb_win_detect.sv
// Combinational window test: raster position relative to the active-area start,
// compared against the buffer window placed at (H_OFF, V_OFF).
module fb_win_detect
    import fb_pkg::*;
#(
    parameter int H_W         = 10,
    parameter int V_W         = 10,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int FB_W        = DEF_FB_W,
    parameter int FB_H        = DEF_FB_H,
    parameter int H_OFF       = 0,
    parameter int V_OFF       = 0
) (
    input  logic [H_W-1:0] hcnt,
    input  logic [V_W-1:0] vcnt,
    input  logic           dena,
    input  logic           armed,
    input  logic           s2,
    output logic           in_win
);

    logic [H_W-1:0] hx;
    logic [V_W-1:0] vy;
    logic           h_in;
    logic           v_in;

    // Positions left of / above the active start wrap to large values and fail the test.
    always_comb begin
        hx     = hcnt - H_W'(H_ACT_START);
        vy     = vcnt - V_W'(V_ACT_START);
        h_in   = (int'(hx) >= H_OFF) && (int'(hx) < H_OFF + win_dim(FB_W, s2));
        v_in   = (int'(vy) >= V_OFF) && (int'(vy) < V_OFF + win_dim(FB_H, s2));
        in_win = dena & armed & h_in & v_in;
    end

endmodule

// File: rtl/fb_addr_gen.sv
// Frame-buffer address generator: incremental col/row_base counters, one-cycle
// registered latency. Optional 2x2 replication when FB_ADDR_SCALE2_EN is defined.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_W         = 10,
    parameter int V_W         = 10,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int FB_W        = DEF_FB_W,
    parameter int FB_H        = DEF_FB_H,
    parameter int H_OFF       = 0,
    parameter int V_OFF       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_W-1:0]    hcnt,
    input  logic [V_W-1:0]    vcnt,
    input  logic              dena,
`ifdef FB_ADDR_SCALE2_EN
    input  logic              scale2,
`endif
    output logic [ADDR_W-1:0] fb_addr,
    output logic              black_flag,
    output logic              addr_valid,
    output logic              frame_start
);

    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    if (longint'(FB_W) * longint'(FB_H) > (longint'(1) << ADDR_W)) begin : g_size_check
        $error("fb_addr_gen: FB_W*FB_H does not fit in ADDR_W bits");
    end

    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;
    logic              armed;
    logic              prev_in_win;
    logic              in_win;
    logic              rearm;
    logic              col_step;
    logic              row_step;
    logic              first_px;
    logic              s2_mode;

    assign rearm = (vcnt < V_W'(V_ACT_START));

    fb_win_detect #(
        .H_W(H_W), .V_W(V_W), .H_ACT_START(H_ACT_START), .V_ACT_START(V_ACT_START),
        .FB_W(FB_W), .FB_H(FB_H), .H_OFF(H_OFF), .V_OFF(V_OFF)
    ) u_win (
        .hcnt(hcnt), .vcnt(vcnt), .dena(dena), .armed(armed), .s2(s2_mode), .in_win(in_win)
    );

`ifdef FB_ADDR_SCALE2_EN
    logic sub_h;
    logic sub_v;

    // In 2x mode each buffer column/row is held for two screen pixels/lines.
    always_comb begin
        col_step = ~s2_mode | sub_h;
        row_step = ~s2_mode | sub_v;
        first_px = ~sub_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_h   <= 1'b0;
            sub_v   <= 1'b0;
            s2_mode <= 1'b0;
        end else if (rearm) begin
            sub_h   <= 1'b0;
            sub_v   <= 1'b0;
            s2_mode <= scale2;
        end else if (in_win) begin
            sub_h <= s2_mode & ~sub_h;
        end else if (prev_in_win) begin
            sub_h <= 1'b0;
            sub_v <= s2_mode & ~sub_v;
        end
    end
`else
    always_comb begin
        col_step = 1'b1;
        row_step = 1'b1;
        first_px = 1'b1;
        s2_mode  = 1'b0;
    end
`endif

    // armed stays low after a reset until vertical blanking, so a mid-frame
    // reset blanks the rest of the frame instead of issuing shifted addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row_base    <= '0;
            armed       <= 1'b0;
            prev_in_win <= 1'b0;
            fb_addr     <= '0;
            black_flag  <= 1'b1;
            addr_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            prev_in_win <= in_win;
            fb_addr     <= in_win ? row_base + col : '0;
            black_flag  <= ~in_win;
            addr_valid  <= in_win;
            frame_start <= in_win & (row_base == '0) & (col == '0) & ~prev_in_win & first_px;
            if (rearm) begin
                armed    <= 1'b1;
                col      <= '0;
                row_base <= '0;
            end else if (in_win) begin
                if (col_step) col <= col + 1'b1;
            end else if (prev_in_win) begin
                col <= '0;
                if (row_step) row_base <= row_base + FB_W_A;
            end
        end
    end

endmodule

// File: tb/tb_fb_addr_gen.sv
// Bench for fb_addr_gen: three configurations driven by one randomized raster
// stream, checked against a pixel/line counting reference model.
`timescale 1ns/1ps
module tb_fb_addr_gen;

    localparam int NDUT   = 3;
    localparam int ADDR_W = 19;
`ifdef FB_ADDR_SCALE2_EN
    localparam bit S2_BUILD = 1'b1;
`else
    localparam bit S2_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              black;
        logic              valid;
        logic              fs;
    } exp_t;
    typedef exp_t [NDUT-1:0] exp_vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [9:0]        hcnt = '0;
    logic [9:0]        vcnt = '0;
    logic              dena = 1'b0;
    logic              sc2 = 1'b0;
    logic              s2_req = 1'b0;
    logic [ADDR_W-1:0] addr [NDUT];
    logic              black [NDUT];
    logic              valid [NDUT];
    logic              fs [NDUT];

    always #5 clk = ~clk;

    fb_addr_gen u_dut0 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .dena(dena),
`ifdef FB_ADDR_SCALE2_EN
        .scale2(1'b0),
`endif
        .fb_addr(addr[0]), .black_flag(black[0]), .addr_valid(valid[0]), .frame_start(fs[0])
    );

    fb_addr_gen #(.FB_W(320), .FB_H(240), .H_OFF(160), .V_OFF(120)) u_dut1 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .dena(dena),
`ifdef FB_ADDR_SCALE2_EN
        .scale2(1'b0),
`endif
        .fb_addr(addr[1]), .black_flag(black[1]), .addr_valid(valid[1]), .frame_start(fs[1])
    );

    fb_addr_gen #(.FB_W(320), .FB_H(240)) u_dut2 (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .dena(dena),
`ifdef FB_ADDR_SCALE2_EN
        .scale2(sc2),
`endif
        .fb_addr(addr[2]), .black_flag(black[2]), .addr_valid(valid[2]), .frame_start(fs[2])
    );

    // ---------------- reference model ----------------
    function automatic int cfg_fbw(input int i);
        return (i == 0) ? 640 : 320;
    endfunction
    function automatic int cfg_fbh(input int i);
        return (i == 0) ? 480 : 240;
    endfunction
    function automatic int cfg_hoff(input int i);
        return (i == 1) ? 160 : 0;
    endfunction
    function automatic int cfg_voff(input int i);
        return (i == 1) ? 120 : 0;
    endfunction

    // Per configuration: completed window lines and window pixels on the current line.
    int m_line [NDUT];
    int m_pix  [NDUT];
    bit m_armed [NDUT];
    bit m_prev [NDUT];
    bit m_s2 [NDUT];

    task automatic model_step(input logic [9:0] h, input logic [9:0] v, input logic d,
                              input logic r, input logic s, output exp_vec_t e);
        for (int i = 0; i < NDUT; i++) begin
            int sf;
            int hx;
            int vy;
            int a;
            bit inw;
            e[i] = '{addr: '0, black: 1'b1, valid: 1'b0, fs: 1'b0};
            if (r) begin
                m_armed[i] = 1'b0;
                m_line[i]  = 0;
                m_pix[i]   = 0;
                m_prev[i]  = 1'b0;
                m_s2[i]    = 1'b0;
            end else begin
                sf  = m_s2[i] ? 2 : 1;
                hx  = (int'(h) - 144) & 1023;
                vy  = (int'(v) - 35) & 1023;
                inw = d && m_armed[i]
                      && hx >= cfg_hoff(i) && hx < cfg_hoff(i) + cfg_fbw(i) * sf
                      && vy >= cfg_voff(i) && vy < cfg_voff(i) + cfg_fbh(i) * sf;
                if (inw) begin
                    a = (m_line[i] / sf) * cfg_fbw(i) + m_pix[i] / sf;
                    e[i].addr  = ADDR_W'(a);
                    e[i].black = 1'b0;
                    e[i].valid = 1'b1;
                    e[i].fs    = (m_line[i] == 0) && (m_pix[i] == 0) && !m_prev[i];
                end
                if (int'(v) < 35) begin
                    m_armed[i] = 1'b1;
                    m_line[i]  = 0;
                    m_pix[i]   = 0;
                    if (i == 2 && S2_BUILD) m_s2[i] = s;
                end else if (inw) begin
                    m_pix[i] = m_pix[i] + 1;
                end else if (m_prev[i]) begin
                    m_line[i] = m_line[i] + 1;
                    m_pix[i]  = 0;
                end
                m_prev[i] = inw;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    exp_vec_t exp_q [$];
    exp_vec_t ev;
    int       n_assert = 0;
    int       n_fail   = 0;

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t h=%0d v=%0d got %0d expected %0d",
                     name, i, $time, hcnt, vcnt, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            for (int i = 0; i < NDUT; i++) begin
                chk("fb_addr", i, int'(addr[i]), int'(ev[i].addr));
                chk("black_flag", i, int'(black[i]), int'(ev[i].black));
                chk("addr_valid", i, int'(valid[i]), int'(ev[i].valid));
                chk("frame_start", i, int'(fs[i]), int'(ev[i].fs));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic d, input logic r);
        exp_vec_t e;
        @(negedge clk);
        hcnt = h;
        vcnt = v;
        dena = d;
        rst  = r;
        sc2  = s2_req;
        model_step(h, v, d, r, s2_req, e);
        exp_q.push_back(e);
    endtask

    task automatic vblank();
        cyc(10'd300, 10'd0, 1'b0, 1'b0);
        cyc(10'd300, 10'd20, 1'b0, 1'b0);
        cyc(10'd300, 10'd33, 1'b0, 1'b0);
        cyc(10'd300, 10'd34, 1'b1, 1'b0);
        cyc(10'd144, 10'd34, 1'b1, 1'b0);
    endtask

    task automatic full_line(input int v);
        cyc(10'd143, 10'(v), 1'b1, 1'b0);
        for (int h = 144; h <= 783; h++) cyc(10'(h), 10'(v), 1'b1, 1'b0);
        cyc(10'd784, 10'(v), 1'b1, 1'b0);
        cyc(10'd0, 10'(v), 1'b0, 1'b0);
    endtask

    // A short contiguous run that always touches the full-width window, then one of several blank kinds.
    task automatic sparse_line(input int v);
        int start;
        int len;
        int kind;
        start = int'($urandom_range(144, 783));
        len   = int'($urandom_range(1, 8));
        cyc(10'($urandom_range(0, 143)), 10'(v), 1'b1, 1'b0);
        for (int k = 0; k < len; k++) cyc(10'(start + k), 10'(v), 1'b1, 1'b0);
        kind = int'($urandom_range(0, 2));
        case (kind)
            0:       cyc(10'd0, 10'(v), 1'b0, 1'b0);
            1:       cyc(10'd784, 10'(v), 1'b1, 1'b0);
            default: cyc(10'($urandom_range(144, 783)), 10'(v), 1'b0, 1'b0);
        endcase
    endtask

    task automatic run_frame(input int last_line, input int tog_line, input int rst_line);
        vblank();
        for (int v = 35; v <= last_line; v++) begin
            if (v == tog_line) s2_req = ~s2_req;
            if (v == rst_line) begin
                cyc(10'd399, 10'(v), 1'b1, 1'b0);
                cyc(10'd400, 10'(v), 1'b1, 1'b1);
                cyc(10'd401, 10'(v), 1'b1, 1'b0);
                cyc(10'd0, 10'(v), 1'b0, 1'b0);
            end else if (v inside {35, 36, 37, 155, 156, 300, 514}) begin
                full_line(v);
            end else begin
                sparse_line(v);
            end
        end
        cyc(10'd300, 10'd515, 1'b1, 1'b0);
        cyc(10'd783, 10'd515, 1'b1, 1'b0);
        cyc(10'd500, 10'd520, 1'b0, 1'b0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        cyc(10'd0, 10'd0, 1'b0, 1'b1);
        cyc(10'd144, 10'd35, 1'b1, 1'b1);
        cyc(10'd144, 10'd35, 1'b1, 1'b0);
        cyc(10'd0, 10'd35, 1'b0, 1'b0);

        s2_req = 1'b0;
        run_frame(514, -1, -1);
        s2_req = 1'b1;
        run_frame(514, 200, -1);
        run_frame(514, -1, 200);
        run_frame(40, -1, -1);

        repeat (3) @(posedge clk);
        #2;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
